// File: rtl/jk_counter_pkg.sv
// Shared types and helpers for the JK modulo counter.
//   jk_mode_t : counter operating mode (HOLD/UP/DOWN/LOAD)
//   jk_pair_t : J/K drive for one storage bit
//   jk_pair() : J/K drive that moves one bit from its current value q to nxt
package jk_counter_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } jk_mode_t;

  typedef struct packed {
    logic j;
    logic k;
  } jk_pair_t;

  // Set when the bit must rise, reset when it must fall, otherwise hold.
  // J and K are never both high.
  function automatic jk_pair_t jk_pair(input logic q, input logic nxt);
    jk_pair_t p;
    p.j = nxt & ~q;
    p.k = ~nxt & q;
    return p;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// One JK storage bit with clock enable.
//   clk, rst : rising-edge clock, asynchronous active-high reset to RST_VAL
//   en       : cell updates only when high
//   j, k     : 00 hold, 01 reset, 10 set, 11 toggle
//   q        : stored bit
module jk_cell #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS up/down/load counter built from WIDTH JK cells.
//   clk, rst  : rising-edge clock, asynchronous active-high reset (q=RESET_VAL)
//   en        : count/load enable; when low q holds and the pulses clear
//   mode      : 00 HOLD, 01 UP, 10 DOWN, 11 LOAD
//   load_val  : value captured in LOAD mode (out-of-range saturates to MODULUS-1)
//   clr       : synchronous clear to RESET_VAL, only with JK_MOD_COUNTER_SYNC_CLR_EN
//   q, q_bar  : counter value and its complement (q_bar combinational)
//   tc        : combinational terminal count for the current mode
//   wrap      : one-cycle pulse aligned with a wrapped q
//   load_err  : one-cycle pulse aligned with a saturated load
// Optional feature macro: JK_MOD_COUNTER_SYNC_CLR_EN
module jk_mod_counter
  import jk_counter_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter longint unsigned  MODULUS   = 256,
  parameter longint unsigned  RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] load_val,
`ifdef JK_MOD_COUNTER_SYNC_CLR_EN
  input  logic             clr,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  localparam int unsigned      EXT_W   = WIDTH + 1;
  localparam logic [WIDTH:0]   MOD_EXT = EXT_W'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);

  jk_mode_t         mode_e;
  logic [WIDTH:0]   inc_ext;
  logic [WIDTH:0]   dec_ext;
  logic [WIDTH:0]   ld_ext;
  logic [WIDTH-1:0] nxt;
  logic             wrap_nxt;
  logic             err_nxt;
  logic             cell_en;

  assign mode_e  = jk_mode_t'(mode);

  // One extra bit so MODULUS = 2**WIDTH compares without aliasing to zero
  assign inc_ext = {1'b0, q} + EXT_W'(1);
  assign dec_ext = {1'b0, q} - EXT_W'(1);
  assign ld_ext  = {1'b0, load_val};

  // Next counter value and pulse requests
  always_comb begin
    nxt      = q;
    wrap_nxt = 1'b0;
    err_nxt  = 1'b0;
    if (en) begin
      case (mode_e)
        MODE_UP: begin
          if (inc_ext == MOD_EXT) begin
            nxt      = '0;
            wrap_nxt = 1'b1;
          end else begin
            nxt = inc_ext[WIDTH-1:0];
          end
        end
        MODE_DOWN: begin
          // Borrow into the extra bit means q was zero
          if (dec_ext[WIDTH]) begin
            nxt      = MAX_VAL;
            wrap_nxt = 1'b1;
          end else begin
            nxt = dec_ext[WIDTH-1:0];
          end
        end
        MODE_LOAD: begin
          if (ld_ext < MOD_EXT) begin
            nxt = load_val;
          end else begin
            nxt     = MAX_VAL;
            err_nxt = 1'b1;
          end
        end
        default: nxt = q;
      endcase
    end
`ifdef JK_MOD_COUNTER_SYNC_CLR_EN
    if (clr) begin
      nxt      = RST_VAL;
      wrap_nxt = 1'b0;
      err_nxt  = 1'b0;
    end
`endif
  end

`ifdef JK_MOD_COUNTER_SYNC_CLR_EN
  assign cell_en = en | clr;
`else
  assign cell_en = en;
`endif

  // Storage: one JK cell per bit, driven to move q toward nxt
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    jk_pair_t drv;
    assign drv = jk_pair(q[i], nxt[i]);
    jk_cell #(
      .RST_VAL (RST_VAL[i])
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .en  (cell_en),
      .j   (drv.j),
      .k   (drv.k),
      .q   (q[i])
    );
  end

  // Registered one-cycle status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= wrap_nxt;
      load_err <= err_nxt;
    end
  end

  assign q_bar = ~q;
  assign tc    = ((mode_e == MODE_UP) && (q == MAX_VAL)) ||
                 ((mode_e == MODE_DOWN) && (q == '0));

endmodule

// File: doc/jk_mod_counter.md
# jk_mod_counter

Parametrised modulo-N up/down/load counter built from an array of JK storage cells, each with per-bit J/K drive and enable. It replaces single-bit JK flip-flops wherever the design needs multi-bit state with hold, count, and load modes. It also provides terminal-count and wrap indications for cascading timers and dividers.

## Interface
- WIDTH, 8, counter width in bits (1..32)
- MODULUS, 256, count range 0..MODULUS-1; legal 2..2**WIDTH
- RESET_VAL, 0, value of q after reset; must be < MODULUS
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  count/load enable; en=0 holds all state except the wrap/load_err pulses, which clear
- mode  in  2  00 HOLD, 01 UP, 10 DOWN, 11 LOAD
- load_val  in  WIDTH  value captured in LOAD mode
- q  out  WIDTH  counter value
- q_bar  out  WIDTH  bitwise ~q, combinational
- tc  out  1  terminal count, combinational: (mode==UP && q==MODULUS-1) || (mode==DOWN && q==0); independent of en
- wrap  out  1  registered one-cycle pulse, high in the cycle after q wrapped
- load_err  out  1  registered one-cycle pulse, high in the cycle after an out-of-range load

## Operation
- The reset state persists while rst is high: q=RESET_VAL, wrap=0, load_err=0.
- Next value nxt is computed per mode when en=1:
  - HOLD: nxt = q.
  - UP: nxt = q+1; if q==MODULUS-1, nxt = 0 and wrap is set.
  - DOWN: nxt = q-1; if q==0, nxt = MODULUS-1 and wrap is set.
  - LOAD: nxt = load_val if load_val < MODULUS; otherwise nxt = MODULUS-1 and load_err is set.
- Each bit i is driven as a JK cell: J = nxt[i] & ~q[i], K = ~nxt[i] & q[i]. J=K=0 holds the bit. J=K=1 never occurs.
- Arithmetic is done in WIDTH+1 bits so that MODULUS=2**WIDTH wraps correctly with no overflow aliasing.
- The comparison against MODULUS uses WIDTH+1-bit constants. load_val is zero-extended before the compare.
- With en=0, q holds regardless of mode, and wrap and load_err are 0 on the next cycle.
- A mode change takes effect on the next clock edge; no state is carried between modes.

## Timing
- Latency is 1 cycle: q reflects nxt after the rising edge where en=1.
- wrap and load_err are asserted for exactly one cycle, aligned with the new q. Back-to-back wraps (e.g. MODULUS=2 counting up) pulse wrap every wrapping cycle.
- tc is purely combinational on q and mode, so a cascaded stage uses (en & tc) as its enable in the same cycle.
- rst asserted mid-count forces q=RESET_VAL immediately (asynchronously), and both pulses clear. The first count happens on the first rising edge after rst deasserts.

## Configuration
- JK_MOD_COUNTER_SYNC_CLR_EN:
  - When defined, adds input port clr (1 bit). clr=1 sets q=RESET_VAL on the next edge, takes priority over en and mode, and forces wrap=0 and load_err=0.
  - When undefined, the port is absent and behaviour is exactly as described above.

## Structure
- Package jk_counter_pkg holds:
  - typedef enum logic [1:0] jk_mode_t {MODE_HOLD, MODE_UP, MODE_DOWN, MODE_LOAD};
  - a function computing J/K pairs from (q, nxt).
- Sub-module jk_cell: one JK bit with inputs clk, rst, en, j, k, output q, and parameter RST_VAL. It is instantiated WIDTH times via generate, with RST_VAL = RESET_VAL[i].

## Test plan
- Reset with RESET_VAL=5, WIDTH=4, MODULUS=10 → q=5 while rst=1; wrap=0; load_err=0.
- UP from 7, MODULUS=10, 4 cycles → q=8,9,0,1; tc=1 while q=9; wrap high only in the cycle q=0.
- DOWN from 1, MODULUS=10 → q=0, then 9; wrap pulses with q=9; LOAD load_val=12 → q=9, load_err pulses once.
- WIDTH=8, MODULUS=256, UP from 255 → q=0 with wrap=1; en=0 during UP → q frozen, wrap=0.
- Assert rst asynchronously between edges while q=6 → q=RESET_VAL before the next edge; after release, counting resumes from RESET_VAL.
- With JK_MOD_COUNTER_SYNC_CLR_EN, clr=1 together with LOAD load_val=3 → q=RESET_VAL and load_err=0.
